// File: rtl/bcd_7seg_mux.sv
// ---------------------------------------------------------------------------
// bcd_7seg_mux
//
// Two-digit, time-multiplexed 7-segment display driver. A tens/units BCD
// pair is captured on `load` and scanned onto a shared segment bus using
// one-hot digit enables. A one-cycle dead gap separates the two digits so
// that the segment pattern of one digit never ghosts onto the other.
//
// Parameters
//   REFRESH_DIV : cycles each digit is shown per frame (>= 1).
//                 Frame period is 2*REFRESH_DIV + 2 cycles.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   load       in   1  capture tens/units on this edge
//   tens       in   4  BCD tens digit (10..15 shown as a dash)
//   units      in   4  BCD units digit (10..15 shown as a dash)
//   blank_lz   in   1  blank the tens digit when the held tens value is 0
//                      (live input, not latched)
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-high
//   an         out  2  digit enables, active-high; an[0]=units, an[1]=tens
//   frame_done out  1  one-cycle pulse in the gap that ends each frame
// ---------------------------------------------------------------------------
module bcd_7seg_mux #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_done
);

    // A REFRESH_DIV of 1 still needs a 1-bit counter; $clog2(1) would be 0.
    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_UNITS = 2'd0,
        ST_GAP0  = 2'd1,
        ST_TENS  = 2'd2,
        ST_GAP1  = 2'd3
    } state_t;

    // BCD digit to active-high segment pattern; invalid codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;

    // Digit holding registers: both digits update together on load.
    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (load) begin
            tens_d  = tens;
            units_d = units;
        end else begin
            tens_d  = tens_q;
            units_d = units_q;
        end
    end

    // Scan sequencing: display states dwell REFRESH_DIV cycles, gaps one cycle.
    // The counter is only meaningful in the display states and is zero on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_UNITS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_GAP0;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_UNITS;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_GAP0: begin
                state_d = ST_TENS;
                cnt_d   = CNT_ZERO;
            end
            ST_TENS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_GAP1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_TENS;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_GAP1: begin
                state_d = ST_UNITS;
                cnt_d   = CNT_ZERO;
            end
            default: begin
                state_d = ST_UNITS;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, phase counter and digit registers; reset clears all of them
    // without waiting for a clock, and wins over a coincident load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNITS;
            cnt_q   <= CNT_ZERO;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    // Output decode from held state only; blank_lz is deliberately live so
    // leading-zero blanking can be toggled without reloading the digits.
    always_comb begin
        seg        = 7'h00;
        an         = 2'b00;
        frame_done = 1'b0;
        case (state_q)
            ST_UNITS: begin
                an  = 2'b01;
                seg = bcd_to_seg(units_q);
            end
            ST_GAP0: begin
                an  = 2'b00;
                seg = 7'h00;
            end
            ST_TENS: begin
                if (blank_lz && (tens_q == 4'd0)) begin
                    an  = 2'b00;
                    seg = 7'h00;
                end else begin
                    an  = 2'b10;
                    seg = bcd_to_seg(tens_q);
                end
            end
            ST_GAP1: begin
                an         = 2'b00;
                seg        = 7'h00;
                frame_done = 1'b1;
            end
            default: begin
                an         = 2'b00;
                seg        = 7'h00;
                frame_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_7seg_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_7seg_mux
//
// Drives two instances (REFRESH_DIV = 4 and REFRESH_DIV = 1) from the same
// inputs. A reference model tracks the held digits and the number of clock
// edges since reset; the expected display for each cycle follows from that
// edge count modulo the frame period. Expectations are queued by the driver
// and popped/compared by an independent monitor each cycle.
// ---------------------------------------------------------------------------
module tb_bcd_7seg_mux;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] tens;
    logic [3:0] units;
    logic       blank_lz;

    logic [6:0] seg4, seg1;
    logic [1:0] an4, an1;
    logic       fd4, fd1;

    bcd_7seg_mux #(.REFRESH_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .tens(tens), .units(units),
        .blank_lz(blank_lz), .seg(seg4), .an(an4), .frame_done(fd4)
    );

    bcd_7seg_mux #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .tens(tens), .units(units),
        .blank_lz(blank_lz), .seg(seg1), .an(an1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] s4;
        logic [1:0] a4;
        logic       f4;
        logic [6:0] s1;
        logic [1:0] a1;
        logic       f1;
    } exp_t;

    exp_t exp_q[$];

    int tests  = 0;
    int errors = 0;

    logic [6:0] seg_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                   7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
                                   7'h40, 7'h40, 7'h40, 7'h40};

    // model state
    logic [3:0] m_tens  = 4'd0;
    logic [3:0] m_units = 4'd0;
    int         m_cyc   = 0;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Display expected for a frame of period 2d+2 at edge count c.
    function automatic void model_out(input int d, input int c, input logic [3:0] ht,
                                      input logic [3:0] hu, input logic blz,
                                      output logic [6:0] s, output logic [1:0] a,
                                      output logic f);
        int ph;
        ph = c % (2 * d + 2);
        s = 7'h00; a = 2'b00; f = 1'b0;
        if (ph < d) begin
            a = 2'b01; s = seg_tbl[hu];
        end else if (ph == d) begin
            a = 2'b00;
        end else if (ph <= 2 * d) begin
            if (!(blz && ht == 4'd0)) begin
                a = 2'b10; s = seg_tbl[ht];
            end
        end else begin
            f = 1'b1;
        end
    endfunction

    // One clock cycle of stimulus: drive at negedge, queue expectation,
    // advance the model on the following posedge.
    task automatic drive_cycle(input logic ld, input logic [3:0] t, input logic [3:0] u,
                               input logic blz, input logic r);
        exp_t e;
        logic [6:0] s; logic [1:0] a; logic f;
        @(negedge clk);
        load = ld; tens = t; units = u; blank_lz = blz; rst = r;
        if (r) begin
            m_tens = 4'd0; m_units = 4'd0; m_cyc = 0;
        end
        model_out(4, m_cyc, m_tens, m_units, blz, s, a, f);
        e.s4 = s; e.a4 = a; e.f4 = f;
        model_out(1, m_cyc, m_tens, m_units, blz, s, a, f);
        e.s1 = s; e.a1 = a; e.f1 = f;
        exp_q.push_back(e);
        @(posedge clk);
        if (!r) begin
            if (ld) begin
                m_tens = t; m_units = u;
            end
            m_cyc++;
        end
    endtask

    task automatic idle(input int n, input logic blz);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'd0, 4'd0, blz, 1'b0);
    endtask

    // Monitor: every cycle the DUTs present a display word; compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seg_div4", seg4, e.s4);
                chk("an_div4", {5'd0, an4}, {5'd0, e.a4});
                chk("frame_done_div4", {6'd0, fd4}, {6'd0, e.f4});
                chk("seg_div1", seg1, e.s1);
                chk("an_div1", {5'd0, an1}, {5'd0, e.a1});
                chk("frame_done_div1", {6'd0, fd1}, {6'd0, e.f1});
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; tens = 4'd0; units = 4'd0; blank_lz = 1'b0;
        #1;
        chk("reset_an", {5'd0, an4}, 7'h01);
        chk("reset_seg", seg4, 7'h3F);
        chk("reset_fd", {6'd0, fd4}, 7'h00);
        repeat (2) @(posedge clk);

        // reset with a coincident load: reset wins
        drive_cycle(1'b1, 4'd8, 4'd8, 1'b0, 1'b1);
        drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        idle(10, 1'b0);

        // tens=1 units=7 for two full frames
        drive_cycle(1'b1, 4'd1, 4'd7, 1'b0, 1'b0);
        idle(20, 1'b0);

        // leading-zero blanking, then without
        drive_cycle(1'b1, 4'd0, 4'd5, 1'b1, 1'b0);
        idle(10, 1'b1);
        idle(10, 1'b0);

        // invalid BCD
        drive_cycle(1'b1, 4'd12, 4'd15, 1'b0, 1'b0);
        idle(10, 1'b0);

        // load mid-frame at UNITS counter 2 (phase 2 of the div-4 frame)
        while ((m_cyc % 10) != 2) drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive_cycle(1'b1, 4'd2, 4'd9, 1'b0, 1'b0);
        idle(12, 1'b0);

        // sweep all units digits, one load per frame
        for (int i = 0; i < 10; i++) begin
            while ((m_cyc % 10) != 0) drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
            drive_cycle(1'b1, 4'(9 - i), 4'(i), 1'b0, 1'b0);
            idle(9, 1'b0);
        end

        // asynchronous reset while in TENS showing a 3
        drive_cycle(1'b1, 4'd3, 4'd4, 1'b0, 1'b0);
        while ((m_cyc % 10) < 5 || (m_cyc % 10) > 8) drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        #3;
        rst = 1'b1;
        m_tens = 4'd0; m_units = 4'd0; m_cyc = 0;
        #1;
        chk("async_rst_an", {5'd0, an4}, 7'h01);
        chk("async_rst_seg", seg4, 7'h3F);
        chk("async_rst_fd", {6'd0, fd4}, 7'h00);
        drive_cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        idle(14, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 99) == 0));
        end

        // let the monitor drain; bounded wait
        repeat (3) @(negedge clk);
        #4;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
